// File: rtl/itc99_b13_rx.sv
// Serial frame receiver for the b13 transmitter: start / 8 data / stop, timed from the start pulse.
// Optional build macro RX_GLITCH_CHECK_EN turns a low line on any non-sample edge into a framing error.
module itc99_b13_rx #(
  parameter int BIT_PERIOD = 106
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       dsr,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  localparam logic [9:0] LAST_COUNT = 10'(BIT_PERIOD - 1);

  state_t     state;
  logic [9:0] interval_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;

  logic sample_edge;
  logic stop_sample;
  logic good_frame;
  logic glitch;
  logic consume;
  logic overrun_hit;
  logic err_event;

  // The counter restarts at every sample edge, so a count of BIT_PERIOD-1 marks the next sample edge.
  assign sample_edge = (interval_cnt == LAST_COUNT);
  assign stop_sample = (state == STOP) && sample_edge;
  assign good_frame  = stop_sample && serial_in;
  assign consume     = rx_valid && rx_ready;
  assign overrun_hit = good_frame && rx_valid && !rx_ready;

`ifdef RX_GLITCH_CHECK_EN
  assign glitch = (state != IDLE) && !sample_edge && !serial_in;
`else
  assign glitch = 1'b0;
`endif

  assign err_event = (stop_sample && !serial_in) || glitch || overrun_hit;
  assign dsr       = ~rx_valid;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      interval_cnt <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      err_count    <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (consume)
        rx_valid <= 1'b0;
      if (err_event && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;

      case (state)
        IDLE: begin
          interval_cnt <= '0;
          bit_idx      <= '0;
          if (!serial_in)
            state <= DATA;
        end
        DATA: begin
          if (glitch) begin
            frame_err    <= 1'b1;
            interval_cnt <= '0;
            state        <= IDLE;
          end else if (sample_edge) begin
            shift_reg    <= {shift_reg[6:0], serial_in};
            interval_cnt <= '0;
            bit_idx      <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= STOP;
          end else begin
            interval_cnt <= interval_cnt + 10'd1;
          end
        end
        STOP: begin
          if (glitch) begin
            frame_err    <= 1'b1;
            interval_cnt <= '0;
            state        <= IDLE;
          end else if (sample_edge) begin
            interval_cnt <= '0;
            state        <= IDLE;
            // A full holding register only takes the new byte if it is being consumed on this edge.
            if (serial_in) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            interval_cnt <= interval_cnt + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_itc99_b13_rx.sv
// Directed bench for itc99_b13_rx: frames are driven in transmitter format with hand-computed results.
// Works with or without RX_GLITCH_CHECK_EN defined.
module tb_itc99_b13_rx;

  localparam int BP = 20;

  logic       clock;
  logic       reset_n;
  logic       serial_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       dsr;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [7:0] err_count;

  int checks;
  int errors;
  int exp_err;

  itc99_b13_rx #(.BIT_PERIOD(BP)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .serial_in (serial_in),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .dsr       (dsr),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic bump_err();
    if (exp_err < 255)
      exp_err++;
  endtask

  // Drives one frame starting at the next negedge; returns just after the stop-sample edge
  // (or just after the glitch edge when the glitch check is built in and a glitch is injected).
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int glitch_at,
                               input logic ready_at_stop, input int reset_at);
    @(negedge clock);
    serial_in = 1'b0;
    for (int e = 1; e <= 9 * BP; e++) begin
      int   k;
      logic v;
      @(negedge clock);
      if (e == reset_at) begin
        reset_n = 1'b0;
        #2;
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_dsr", dsr, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_err_count", err_count, 8'h00);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        checkOutput("reset_overrun", overrun, 1'b0);
        reset_n = 1'b1;
      end
      k = e / BP;
      if (e % BP == 0)
        v = (k <= 8) ? data[8 - k] : stop_bit;
      else if (e == glitch_at)
        v = 1'b0;
      else
        v = 1'b1;
      serial_in = v;
      rx_ready  = ready_at_stop && (e == 9 * BP);
      if ((e == 9 * BP) && (reset_at == 0))
        checkOutput("busy_before_stop", busy, 1'b1);
`ifdef RX_GLITCH_CHECK_EN
      if ((glitch_at != 0) && (e == glitch_at)) begin
        @(negedge clock);
        serial_in = 1'b1;
        return;
      end
`endif
    end
    @(negedge clock);
    serial_in = 1'b1;
    rx_ready  = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clock);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  initial begin
    clock     = 1'b0;
    reset_n   = 1'b0;
    serial_in = 1'b1;
    rx_ready  = 1'b0;
    checks    = 0;
    errors    = 0;
    exp_err   = 0;
    repeat (3) @(negedge clock);

    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_rx_valid", rx_valid, 1'b0);
    checkOutput("rst_dsr", dsr, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_frame_err", frame_err, 1'b0);
    checkOutput("rst_overrun", overrun, 1'b0);
    checkOutput("rst_err_count", err_count, 8'h00);
    reset_n = 1'b1;
    @(negedge clock);

    // Nominal frame
    applyStimulus(8'hA5, 1'b1, 0, 1'b0, 0);
    checkOutput("nom_rx_valid", rx_valid, 1'b1);
    checkOutput("nom_rx_data", rx_data, 8'hA5);
    checkOutput("nom_dsr", dsr, 1'b0);
    checkOutput("nom_busy", busy, 1'b0);
    checkOutput("nom_frame_err", frame_err, 1'b0);
    checkOutput("nom_overrun", overrun, 1'b0);

    // Overrun with the holding register full
    applyStimulus(8'h3C, 1'b1, 0, 1'b0, 0);
    bump_err();
    checkOutput("ovr_pulse", overrun, 1'b1);
    checkOutput("ovr_rx_data", rx_data, 8'hA5);
    checkOutput("ovr_rx_valid", rx_valid, 1'b1);
    checkOutput("ovr_err_count", err_count, 8'(exp_err));
    @(negedge clock);
    checkOutput("ovr_pulse_end", overrun, 1'b0);

    // Handshake with no frame completing
    handshake();
    checkOutput("hs_rx_valid", rx_valid, 1'b0);
    checkOutput("hs_dsr", dsr, 1'b1);
    checkOutput("hs_rx_data", rx_data, 8'hA5);

    // Consume and reload on the same edge
    applyStimulus(8'h81, 1'b1, 0, 1'b0, 0);
    checkOutput("ld_rx_data", rx_data, 8'h81);
    applyStimulus(8'h7E, 1'b1, 0, 1'b1, 0);
    checkOutput("swap_rx_valid", rx_valid, 1'b1);
    checkOutput("swap_rx_data", rx_data, 8'h7E);
    checkOutput("swap_overrun", overrun, 1'b0);
    checkOutput("swap_err_count", err_count, 8'(exp_err));

    // Bad stop bit
    applyStimulus(8'h55, 1'b0, 0, 1'b0, 0);
    bump_err();
    checkOutput("bad_frame_err", frame_err, 1'b1);
    checkOutput("bad_rx_valid", rx_valid, 1'b1);
    checkOutput("bad_rx_data", rx_data, 8'h7E);
    checkOutput("bad_err_count", err_count, 8'(exp_err));
    @(negedge clock);
    checkOutput("bad_pulse_end", frame_err, 1'b0);
    handshake();
    checkOutput("hs2_rx_valid", rx_valid, 1'b0);

    // Glitch at t+50 (not a sample edge for BP=20)
    applyStimulus(8'h96, 1'b1, 50, 1'b0, 0);
`ifdef RX_GLITCH_CHECK_EN
    bump_err();
    checkOutput("gl_frame_err", frame_err, 1'b1);
    checkOutput("gl_busy", busy, 1'b0);
    checkOutput("gl_err_count", err_count, 8'(exp_err));
    checkOutput("gl_rx_valid", rx_valid, 1'b0);
`else
    checkOutput("gl_rx_valid", rx_valid, 1'b1);
    checkOutput("gl_rx_data", rx_data, 8'h96);
    checkOutput("gl_frame_err", frame_err, 1'b0);
    checkOutput("gl_err_count", err_count, 8'(exp_err));
    handshake();
`endif
    @(negedge clock);
    applyStimulus(8'hC3, 1'b1, 0, 1'b0, 0);
    checkOutput("post_gl_rx_valid", rx_valid, 1'b1);
    checkOutput("post_gl_rx_data", rx_data, 8'hC3);
    checkOutput("post_gl_frame_err", frame_err, 1'b0);

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) begin
      applyStimulus(8'h00, 1'b0, 0, 1'b0, 0);
      bump_err();
    end
    checkOutput("sat_err_count", err_count, 8'hFF);
    checkOutput("sat_exp", exp_err, 255);
    checkOutput("sat_rx_data", rx_data, 8'hC3);

    // Reset in the middle of a frame
    applyStimulus(8'hFF, 1'b1, 0, 1'b0, 100);
    repeat (2) @(negedge clock);
    checkOutput("post_rst_rx_valid", rx_valid, 1'b0);
    checkOutput("post_rst_rx_data", rx_data, 8'h00);
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_err_count", err_count, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
